// File: rtl/sample_interp_feeder_if.sv
`default_nettype none
// ============================================================================
// Module   : sample_interp_feeder_if
// Brief    : Sample input handshake and interpolated output bundle.
// Revision : 1.0
// ============================================================================
interface sample_interp_feeder_if #(
    parameter int SIGNALWIDTH = 16
);
    logic [SIGNALWIDTH-1:0] in_data;
    logic                   in_valid;
    logic                   in_ready;
    logic [SIGNALWIDTH-1:0] q;
    logic                   tick;
    logic                   underrun;

    modport master (
        output in_data,
        output in_valid,
        input  in_ready,
        input  q,
        input  tick,
        input  underrun
    );

    modport slave (
        input  in_data,
        input  in_valid,
        output in_ready,
        output q,
        output tick,
        output underrun
    );
endinterface
`default_nettype wire

// File: rtl/sample_interp_feeder.sv
`default_nettype none
// ============================================================================
// Module   : sample_interp_feeder
// Brief    : FIFO-buffered linear interpolator feeding the PWM/sigma-delta DAC.
// Revision : 1.0
// ============================================================================
module sample_interp_feeder #(
    parameter int SIGNALWIDTH = 16,
    parameter int STEPBITS    = 2,
    parameter int TICKLOG2    = 5,
    parameter int FIFOLOG2    = 2
) (
    input  wire logic                  clk,
    input  wire logic                  reset_n,
    sample_interp_feeder_if.slave      bus
);
    localparam int c_depth = 1 << FIFOLOG2;
    localparam int c_accw  = SIGNALWIDTH + STEPBITS;
    localparam int c_dw    = SIGNALWIDTH + 1;

    localparam logic [SIGNALWIDTH-1:0] c_mid       = {1'b1, {(SIGNALWIDTH-1){1'b0}}};
    localparam logic [FIFOLOG2:0]      c_full      = {1'b1, {FIFOLOG2{1'b0}}};
    localparam logic [FIFOLOG2:0]      c_cnt_one   = 1;
    localparam logic [FIFOLOG2-1:0]    c_ptr_one   = 1;
    localparam logic [STEPBITS-1:0]    c_phase_one = 1;
    localparam logic [TICKLOG2-1:0]    c_tick_one  = 1;

    typedef enum logic [1:0] {
        S_PRIME = 2'd0,
        S_HOLD  = 2'd1,
        S_RUN   = 2'd2
    } state_t;

    state_t                   r_state;
    state_t                   w_state_nxt;
    logic [TICKLOG2-1:0]      r_tickcnt;
    logic [SIGNALWIDTH-1:0]   r_mem [c_depth];
    logic [FIFOLOG2-1:0]      r_wr_ptr;
    logic [FIFOLOG2-1:0]      r_rd_ptr;
    logic [FIFOLOG2:0]        r_count;
    logic [FIFOLOG2:0]        w_count_nxt;
    logic                     r_ready;
    logic [c_accw-1:0]        r_acc;
    logic [c_accw-1:0]        w_acc_nxt;
    logic [SIGNALWIDTH-1:0]   r_cur;
    logic [SIGNALWIDTH-1:0]   w_cur_nxt;
    logic [SIGNALWIDTH-1:0]   r_target;
    logic [SIGNALWIDTH-1:0]   w_target_nxt;
    logic signed [c_dw-1:0]   r_delta;
    logic signed [c_dw-1:0]   w_delta_nxt;
    logic [STEPBITS-1:0]      r_phase;
    logic [STEPBITS-1:0]      w_phase_nxt;
    logic                     r_underrun;
    logic                     w_underrun_nxt;

    logic                     w_tick;
    logic                     w_write;
    logic                     w_pop;
    logic                     w_nonempty;
    logic [SIGNALWIDTH-1:0]   w_head;
    logic [c_accw-1:0]        w_delta_ext;

    assign w_tick      = &r_tickcnt;
    assign w_write     = bus.in_valid && r_ready;
    assign w_nonempty  = (r_count != '0);
    assign w_head      = r_mem[r_rd_ptr];
    assign w_delta_ext = c_accw'(r_delta);

    assign bus.in_ready = r_ready;
    assign bus.q        = r_acc[c_accw-1 -: SIGNALWIDTH];
    assign bus.tick     = w_tick;
    assign bus.underrun = r_underrun;

    // Segment sequencing; every transition is gated by the interpolation tick.
    always_comb begin
        w_state_nxt    = r_state;
        w_acc_nxt      = r_acc;
        w_cur_nxt      = r_cur;
        w_target_nxt   = r_target;
        w_delta_nxt    = r_delta;
        w_phase_nxt    = r_phase;
        w_underrun_nxt = 1'b0;
        w_pop          = 1'b0;
        if (w_tick) begin
            case (r_state)
                S_PRIME: begin
                    if (w_nonempty) begin
                        w_pop        = 1'b1;
                        w_cur_nxt    = w_head;
                        w_target_nxt = w_head;
                        w_acc_nxt    = {w_head, {STEPBITS{1'b0}}};
                        w_state_nxt  = S_HOLD;
                    end
                end
                S_HOLD: begin
                    if (w_nonempty) begin
                        w_pop        = 1'b1;
                        w_target_nxt = w_head;
                        w_delta_nxt  = $signed({1'b0, w_head} - {1'b0, r_cur});
                        w_phase_nxt  = '0;
                        w_state_nxt  = S_RUN;
                    end
                end
                S_RUN: begin
                    if (!(&r_phase)) begin
                        w_acc_nxt   = r_acc + w_delta_ext;
                        w_phase_nxt = r_phase + c_phase_one;
                    end else begin
                        // Snap to the endpoint so truncation never accumulates.
                        w_acc_nxt = {r_target, {STEPBITS{1'b0}}};
                        w_cur_nxt = r_target;
                        if (w_nonempty) begin
                            w_pop        = 1'b1;
                            w_target_nxt = w_head;
                            w_delta_nxt  = $signed({1'b0, w_head} - {1'b0, r_target});
                            w_phase_nxt  = '0;
                        end else begin
                            w_underrun_nxt = 1'b1;
                            w_state_nxt    = S_HOLD;
                        end
                    end
                end
                default: w_state_nxt = S_PRIME;
            endcase
        end
    end

    always_comb begin
        w_count_nxt = r_count;
        if (w_write && !w_pop) begin
            w_count_nxt = r_count + c_cnt_one;
        end else if (!w_write && w_pop) begin
            w_count_nxt = r_count - c_cnt_one;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state    <= S_PRIME;
            r_tickcnt  <= '0;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_ready    <= 1'b0;
            r_acc      <= {c_mid, {STEPBITS{1'b0}}};
            r_cur      <= '0;
            r_target   <= '0;
            r_delta    <= '0;
            r_phase    <= '0;
            r_underrun <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_tickcnt  <= r_tickcnt + c_tick_one;
            r_count    <= w_count_nxt;
            r_ready    <= (w_count_nxt != c_full);
            r_acc      <= w_acc_nxt;
            r_cur      <= w_cur_nxt;
            r_target   <= w_target_nxt;
            r_delta    <= w_delta_nxt;
            r_phase    <= w_phase_nxt;
            r_underrun <= w_underrun_nxt;
            if (w_write) begin
                r_wr_ptr <= r_wr_ptr + c_ptr_one;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_ptr_one;
            end
        end
    end

    // Storage needs no reset: the pointers and count define what is valid.
    always_ff @(posedge clk) begin
        if (w_write) begin
            r_mem[r_wr_ptr] <= bus.in_data;
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_sample_interp_feeder.sv
`default_nettype none
// ============================================================================
// Module   : tb_sample_interp_feeder
// Brief    : Directed bench with a segment-level reference model of the feeder.
// Revision : 1.0
// ============================================================================
module tb_sample_interp_feeder;
    logic clk;
    logic reset_n;
    int   n_checks;
    int   n_errors;

    sample_interp_feeder_if #(.SIGNALWIDTH(16)) bus ();

    sample_interp_feeder #(
        .SIGNALWIDTH (16),
        .STEPBITS    (2),
        .TICKLOG2    (5),
        .FIFOLOG2    (2)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: a queue for the FIFO and a closed-form position
    // inside the current segment (q = floor((4*cur + k*(tgt-cur)) / 4)).
    int m_fifo[$];
    int m_mode;
    int m_q;
    int m_cur;
    int m_tgt;
    int m_k;
    int m_tc;
    bit m_ready;
    bit m_und;
    bit m_valid;

    initial m_valid = 1'b0;

    always @(posedge clk) begin : p_model
        int  avail;
        bit  tick_now;
        bit  wr;
        int  wd;
        if (!reset_n) begin
            m_fifo.delete();
            m_mode  = 0;
            m_q     = 'h8000;
            m_cur   = 0;
            m_tgt   = 0;
            m_k     = 0;
            m_tc    = 0;
            m_ready = 1'b0;
            m_und   = 1'b0;
            m_valid = 1'b1;
        end else begin
            tick_now = (m_tc == 31);
            m_tc     = (m_tc + 1) % 32;
            avail    = m_fifo.size();
            wr       = bus.in_valid && m_ready;
            wd       = int'(bus.in_data);
            m_und    = 1'b0;
            if (tick_now) begin
                if (m_mode == 0) begin
                    if (avail > 0) begin
                        m_cur  = m_fifo.pop_front();
                        m_tgt  = m_cur;
                        m_q    = m_cur;
                        m_mode = 1;
                    end
                end else if (m_mode == 1) begin
                    if (avail > 0) begin
                        m_tgt  = m_fifo.pop_front();
                        m_k    = 0;
                        m_mode = 2;
                    end
                end else begin
                    m_k = m_k + 1;
                    if (m_k < 4) begin
                        m_q = (4 * m_cur + m_k * (m_tgt - m_cur)) / 4;
                    end else begin
                        m_q   = m_tgt;
                        m_cur = m_tgt;
                        if (avail > 0) begin
                            m_tgt = m_fifo.pop_front();
                            m_k   = 0;
                        end else begin
                            m_und  = 1'b1;
                            m_mode = 1;
                        end
                    end
                end
            end
            if (wr) m_fifo.push_back(wd);
            m_ready = (m_fifo.size() != 4);
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (m_valid) begin
            chk("model_q",        int'(bus.q),        m_q);
            chk("model_in_ready", int'(bus.in_ready), int'(m_ready));
            chk("model_tick",     int'(bus.tick),     int'(m_tc == 31));
            chk("model_underrun", int'(bus.underrun), int'(m_und));
        end
    end

    task automatic do_reset(input bit check);
        @(negedge clk);
        reset_n      = 1'b0;
        bus.in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        if (check) begin
            chk("rst_q",        int'(bus.q),        'h8000);
            chk("rst_in_ready", int'(bus.in_ready), 0);
            chk("rst_tick",     int'(bus.tick),     0);
            chk("rst_underrun", int'(bus.underrun), 0);
        end
        reset_n = 1'b1;
    endtask

    // Called at a negedge; returns at the negedge following acceptance.
    task automatic send(input logic [15:0] d);
        bus.in_data  = d;
        bus.in_valid = 1'b1;
        for (int i = 0; i < 400; i++) begin
            if (bus.in_ready) begin
                @(negedge clk);
                bus.in_valid = 1'b0;
                return;
            end
            @(negedge clk);
        end
        chk("send_timeout", 0, 1);
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_tick();
        for (int i = 0; i < 64; i++) begin
            if (bus.tick) return;
            @(negedge clk);
        end
        chk("tick_timeout", 0, 1);
    endtask

    task automatic tick_check(input string name, input int exp_q);
        wait_tick();
        @(negedge clk);
        chk(name, int'(bus.q), exp_q);
    endtask

    initial begin
        n_checks     = 0;
        n_errors     = 0;
        reset_n      = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_data  = '0;

        // Basic rising segment
        do_reset(1'b1);
        send(16'h1000);
        send(16'h2000);
        chk("pre_tick_q", int'(bus.q), 'h8000);
        tick_check("up_prime", 'h1000);
        tick_check("up_hold",  'h1000);
        tick_check("up_s1",    'h1400);
        tick_check("up_s2",    'h1800);
        tick_check("up_s3",    'h1C00);
        tick_check("up_end",   'h2000);
        chk("up_underrun", int'(bus.underrun), 1);

        // Full-scale falling segment
        do_reset(1'b0);
        send(16'hFFFF);
        send(16'h0000);
        tick_check("dn_prime", 'hFFFF);
        tick_check("dn_hold",  'hFFFF);
        tick_check("dn_s1",    'hBFFF);
        tick_check("dn_s2",    'h7FFF);
        tick_check("dn_s3",    'h3FFF);
        tick_check("dn_end",   'h0000);

        // Backpressure with six queued samples
        do_reset(1'b0);
        for (int i = 0; i < 6; i++) begin
            send(16'(16'h1111 * (i + 1)));
            if (i == 3) chk("bp_full_ready", int'(bus.in_ready), 0);
        end
        repeat (800) @(negedge clk);
        chk("bp_last", int'(bus.q), 'h6666);

        // Steady stream at one sample per 128 clocks
        do_reset(1'b0);
        for (int i = 0; i < 8; i++) begin
            send(16'(i * 16'h0400));
            repeat (127) @(negedge clk);
        end
        repeat (300) @(negedge clk);
        chk("steady_last", int'(bus.q), 'h1C00);

        // Reset in the middle of a segment with three samples buffered
        do_reset(1'b0);
        send(16'h0400);
        send(16'h0800);
        send(16'h0C00);
        send(16'h1000);
        send(16'h1400);
        for (int i = 0; i < 3; i++) begin
            wait_tick();
            @(negedge clk);
        end
        reset_n = 1'b0;
        @(negedge clk);
        chk("mid_rst_q",        int'(bus.q),        'h8000);
        chk("mid_rst_in_ready", int'(bus.in_ready), 0);
        chk("mid_rst_underrun", int'(bus.underrun), 0);
        reset_n = 1'b1;
        repeat (100) @(negedge clk);
        chk("mid_rst_no_stale", int'(bus.q), 'h8000);

        // Write coincident with a tick while the FIFO is empty
        do_reset(1'b0);
        wait_tick();
        bus.in_data  = 16'h5A5A;
        bus.in_valid = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b0;
        chk("coinc_hold", int'(bus.q), 'h8000);
        tick_check("coinc_pop", 'h5A5A);

        repeat (4) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
`default_nettype wire
